// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with count, almost flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module sync_fifo_param #(
  parameter  int DATA_W   = 8,
  parameter  int DEPTH    = 16,
  parameter  int AF_LEVEL = 12,
  parameter  int AE_LEVEL = 2,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_signal,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_signal,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_ok, wr_ok;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  assign wr_addr = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr = rd_ptr_q[ADDR_W-1:0];

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a write paired with a read.
  assign rd_ok = read_signal & ~empty;
  assign wr_ok = write_signal & (~full | rd_ok);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_ok) wr_ptr_d = wr_ptr_q + ONE_C;
    if (rd_ok) rd_ptr_d = rd_ptr_q + ONE_C;

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    // Clear first, then OR in the current error so a same-cycle error survives clr_err.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (write_signal && !wr_ok) overflow_d  = 1'b1;
    if (read_signal && empty)   underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem_q[wr_addr] <= data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out   = mem_q[rd_addr];
  assign data_valid = ~empty;
`else
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= rd_ok;
      if (rd_ok) data_out_q <= mem_q[rd_addr];
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (DEPTH=16, DATA_W=8, AF=12, AE=2).
// Covers both output modes depending on SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       write_signal;
  logic [7:0] data_in;
  logic       read_signal;
  logic [7:0] data_out;
  logic       data_valid;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;
  logic       clr_err;

  int total = 0;
  int bad   = 0;

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .write_signal (write_signal),
    .data_in      (data_in),
    .read_signal  (read_signal),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_signal = 1'b0;
    read_signal  = 1'b0;
    clr_err      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; write_signal = 1'b1; read_signal = 1'b0; clr_err = 1'b0; data_in = 8'h99;
    cyc(); cyc();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got %b exp 1", empty); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got %0d exp 0", count); end
    total++; if (full !== 1'b0 || almost_full !== 1'b0) begin bad++; $display("FAIL reset_full got %b%b exp 00", full, almost_full); end
    total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL reset_ae got %b exp 1", almost_empty); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL reset_err got %b%b exp 00", overflow, underflow); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b exp 0", data_valid); end
`ifndef SYNC_FIFO_FWFT_EN
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_dout got %0h exp 0", data_out); end
`endif
    rst = 1'b0;
    idle();
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      write_signal = 1'b1; data_in = 8'(i);
      cyc();
      total++; if (count !== 5'(i)) begin bad++; $display("FAIL fill_count got %0d exp %0d", count, i); end
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got %b exp 1", full); end
    data_in = 8'h11;
    cyc();
    write_signal = 1'b0;
    total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count got %0d exp 16", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    for (int i = 1; i <= 16; i++) begin
      read_signal = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      total++; if (data_out !== 8'(i) || data_valid !== 1'b1) begin bad++; $display("FAIL drain_data got %0h/%b exp %0h/1", data_out, data_valid, i); end
      cyc();
`else
      cyc();
      total++; if (data_out !== 8'(i) || data_valid !== 1'b1) begin bad++; $display("FAIL drain_data got %0h/%b exp %0h/1", data_out, data_valid, i); end
`endif
    end
    read_signal = 1'b0;
    total++; if (empty !== 1'b1 || count !== 5'd0) begin bad++; $display("FAIL drain_empty got %b/%0d exp 1/0", empty, count); end
    cyc();
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got %b exp 0", data_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    clr_err = 1'b1; cyc(); clr_err = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got %b exp 0", overflow); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) begin
      write_signal = 1'b1; data_in = 8'(8'h20 + i);
      cyc();
    end
    read_signal = 1'b1; data_in = 8'hAA;
`ifdef SYNC_FIFO_FWFT_EN
    total++; if (data_out !== 8'h20) begin bad++; $display("FAIL full_rw_data got %0h exp 20", data_out); end
    cyc();
`else
    cyc();
    total++; if (data_out !== 8'h20) begin bad++; $display("FAIL full_rw_data got %0h exp 20", data_out); end
`endif
    write_signal = 1'b0;
    total++; if (count !== 5'd16 || full !== 1'b1) begin bad++; $display("FAIL full_rw_count got %0d/%b exp 16/1", count, full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_rw_ovf got %b exp 0", overflow); end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_d;
      exp_d = (i < 15) ? 8'(8'h21 + i) : 8'hAA;
`ifdef SYNC_FIFO_FWFT_EN
      total++; if (data_out !== exp_d) begin bad++; $display("FAIL full_rw_drain got %0h exp %0h", data_out, exp_d); end
      cyc();
`else
      cyc();
      total++; if (data_out !== exp_d) begin bad++; $display("FAIL full_rw_drain got %0h exp %0h", data_out, exp_d); end
`endif
    end
    write_signal = 1'b1; read_signal = 1'b1; data_in = 8'h55;
    cyc();
    write_signal = 1'b0;
    total++; if (count !== 5'd1) begin bad++; $display("FAIL empty_rw_count got %0d exp 1", count); end
    total++; if (underflow !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL empty_rw_err got %b%b exp 01", overflow, underflow); end
`ifdef SYNC_FIFO_FWFT_EN
    total++; if (data_out !== 8'h55) begin bad++; $display("FAIL empty_rw_data got %0h exp 55", data_out); end
    cyc();
`else
    cyc();
    total++; if (data_out !== 8'h55) begin bad++; $display("FAIL empty_rw_data got %0h exp 55", data_out); end
`endif
    read_signal = 1'b0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL empty_rw_after got %0d exp 0", count); end
    clr_err = 1'b1; cyc(); clr_err = 1'b0;
    total++; if (underflow !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL clr_err got %b%b exp 00", overflow, underflow); end
  endtask

  task automatic test_thresholds();
    for (int k = 1; k <= 13; k++) begin
      write_signal = 1'b1; data_in = 8'(k);
      cyc();
      total++; if (almost_empty !== (k <= 2)) begin bad++; $display("FAIL ae_level count=%0d got %b exp %b", k, almost_empty, (k <= 2)); end
      total++; if (almost_full !== (k >= 12)) begin bad++; $display("FAIL af_level count=%0d got %b exp %b", k, almost_full, (k >= 12)); end
    end
    write_signal = 1'b0; read_signal = 1'b1;
    repeat (13) cyc();
    read_signal = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL thr_drain got %b exp 1", empty); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 5; i++) begin
      write_signal = 1'b1; data_in = 8'(i);
      cyc();
    end
    for (int i = 0; i < 40; i++) begin
      write_signal = (i < 35); data_in = 8'(i + 5);
      read_signal  = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      total++; if (data_out !== 8'(i)) begin bad++; $display("FAIL stream_data got %0h exp %0h", data_out, i); end
      cyc();
`else
      cyc();
      total++; if (data_out !== 8'(i)) begin bad++; $display("FAIL stream_data got %0h exp %0h", data_out, i); end
`endif
      if (i < 35) begin
        total++; if (count !== 5'd5) begin bad++; $display("FAIL stream_count got %0d exp 5", count); end
      end
    end
    idle();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL stream_empty got %b exp 1", empty); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL stream_err got %b%b exp 00", overflow, underflow); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) begin
      write_signal = 1'b1; data_in = 8'(8'hE0 + i);
      cyc();
    end
    write_signal = 1'b0;
    total++; if (count !== 5'd7) begin bad++; $display("FAIL mid_count got %0d exp 7", count); end
    rst = 1'b1; cyc(); rst = 1'b0;
    total++; if (count !== 5'd0 || empty !== 1'b1) begin bad++; $display("FAIL mid_reset got %0d/%b exp 0/1", count, empty); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got %b exp 0", data_valid); end
    write_signal = 1'b1; data_in = 8'h3C;
    cyc();
    write_signal = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
    total++; if (data_out !== 8'h3C || data_valid !== 1'b1) begin bad++; $display("FAIL fwft_show got %0h/%b exp 3c/1", data_out, data_valid); end
    read_signal = 1'b1; cyc(); read_signal = 1'b0;
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL fwft_pop got %b exp 0", data_valid); end
`else
    read_signal = 1'b1; cyc(); read_signal = 1'b0;
    total++; if (data_out !== 8'h3C || data_valid !== 1'b1) begin bad++; $display("FAIL mid_first got %0h/%b exp 3c/1", data_out, data_valid); end
`endif
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL mid_final got %b exp 1", empty); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_thresholds();
    test_stream();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
